codec_serial_master: RTL and testbench
======================================

# codec_serial_master

Bus-functional, synthesizable model of the audio CODEC's side of the serial audio link: generates bit clock and left/right clocks as master, serializes ADC sample pairs onto the ADC data line, and deserializes the DAC data line into sample pairs. It is the far end of the codec interface block and lets the audio path run in FPGA loopback and in simulation without the physical CODEC. Format is I2S: 24-bit samples, MSB first, one-bit delay after the LRCK edge.

## Interface
Parameters:
- DATA_WIDTH, 24, sample width per channel
- SLOT_BITS, 32, BCLK periods per channel slot; must be >= DATA_WIDTH+1
- BCLK_DIV, 16, CLOCK_50 cycles per BCLK half-period; must be >= 2

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run link; low holds link idle
- tx_left, tx_right  in  DATA_WIDTH each  ADC sample pair to serialize
- tx_valid  in  1  tx pair offered
- tx_ready  out  1  holding register empty
- tx_underrun  out  1  one-cycle pulse: frame started with no new pair
- AUD_BCLK  out  1  bit clock
- AUD_ADCLRCK, AUD_DACLRCK  out  1 each  LR clock (identical); low = left
- AUD_ADCDAT  out  1  serial ADC data
- AUD_DACDAT  in  1  serial DAC data
- rx_left, rx_right  out  DATA_WIDTH each  last captured DAC pair
- rx_valid  out  1  one-cycle pulse: new rx pair

One clock (CLOCK_50); reset is asynchronous and active-low. All outputs registered.

## Operation
- Reset values: AUD_BCLK, both LRCKs, AUD_ADCDAT, tx_underrun, rx_valid = 0; rx_left/rx_right = 0; tx_ready = 1; hold and last-sent registers = 0; div counter and bit counter = 0.
- Divider: counts 0..BCLK_DIV-1; at terminal count BCLK toggles and counter wraps. A 0->1 toggle is a "rise event", 1->0 a "fall event".
- Bit counter b: 0..2*SLOT_BITS-1, advances on every fall event, wraps to 0 (frame start). LRCK = (b >= SLOT_BITS), updated with b on the fall event.
- Slot position p = b mod SLOT_BITS. ADCDAT on fall event: p=0 -> 0; p=1..DATA_WIDTH -> shift bit DATA_WIDTH-p (MSB first); else 0.
- TX handshake: accept when tx_valid && tx_ready; captures pair into hold, tx_ready -> 0 next cycle.
- Frame start (fall event making b=0): if hold full, load hold into shift/last-sent, hold empties (tx_ready 1 next cycle); else reload last-sent pair and pulse tx_underrun. The load uses hold contents prior to that cycle; an acceptance in the same cycle lands in hold for the next frame.
- RX: on each rise event sample AUD_DACDAT directly; for p=1..DATA_WIDTH shift into left (LRCK=0) or right (LRCK=1) accumulator. On the rise event at right-slot p=DATA_WIDTH, transfer both accumulators to rx_left/rx_right and pulse rx_valid the following cycle.
- enable low: synchronous idle; counters, BCLK, LRCKs, ADCDAT forced to 0; partially received pair discarded; hold and rx outputs retained; tx handshake still works. Re-enable starts at frame start (first fall event -> b=0 with load).
- Reset mid-frame: all state to reset values immediately.

## Timing
- BCLK period = 2*BCLK_DIV cycles; frame = 2*SLOT_BITS BCLK periods (defaults: 32 cycles, 2048 cycles/frame).
- ADCDAT/LRCK change only on fall events; DACDAT sampled only on rise events (half BCLK setup for the far end).
- First fall event occurs BCLK_DIV*2 cycles after enable rises (BCLK rises first).
- rx_valid: 1 cycle after the rise event for right-slot LSB; exactly one pulse per complete frame.
- tx_underrun / tx_ready update 1 cycle after frame-start fall event.

## Test plan
- BCLK_DIV=2, SLOT_BITS=32, enable=1: BCLK period 4 cycles, LRCK toggles every 128 cycles, 50% duty, b wraps at 64.
- Offer tx pair L=24'hA5_0F3C, R=24'h80_0001 before frame start -> ADCDAT in left slot p=1..24 = A50F3C MSB first, p=0 and p=25..31 zero; right slot = 800001; tx_ready returns 1 after load.
- Loopback AUD_ADCDAT->AUD_DACDAT with pairs 24'h123456/24'hFEDCBA -> rx_left/rx_right match each pair one frame later, single rx_valid per frame.
- No tx_valid for two frames after sending 24'h7FFFFF/24'h000000 -> tx_underrun pulses at each frame start, same pair repeated on ADCDAT.
- tx_valid asserted on the exact frame-start cycle with hold full, then held -> current frame sends old hold, new pair accepted next cycle and sent next frame; no loss or duplicate.
- Drop enable at right slot p=10, re-enable -> no rx_valid for aborted frame, BCLK/LRCK/ADCDAT 0 while idle, restart at b=0; assert reset_n low mid-frame -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/codec_serial_master.sv
// I2S master model of the audio CODEC: drives BCLK/LRCK, serializes ADC sample
// pairs onto AUD_ADCDAT and deserializes AUD_DACDAT into rx sample pairs.
module codec_serial_master #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_DIV   = 16
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tx_left,
    input  logic [DATA_WIDTH-1:0] tx_right,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  AUD_BCLK,
    output logic                  AUD_ADCLRCK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_ADCDAT,
    input  logic                  AUD_DACDAT,
    output logic [DATA_WIDTH-1:0] rx_left,
    output logic [DATA_WIDTH-1:0] rx_right,
    output logic                  rx_valid
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int B_W   = $clog2(2 * SLOT_BITS);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);
    localparam logic [B_W-1:0]   B_MAX   = B_W'(2 * SLOT_BITS - 1);
    localparam logic [B_W-1:0]   SLOT    = B_W'(SLOT_BITS);
    localparam logic [B_W-1:0]   DW_B    = B_W'(DATA_WIDTH);

    logic [DIV_W-1:0]      div_q, div_d;
    logic [B_W-1:0]        b_q, b_d;
    logic                  bclk_q, bclk_d, lrck_q, lrck_d, adcdat_q, adcdat_d;
    logic                  first_q, first_d;
    logic                  tx_ready_q, tx_ready_d, underrun_q, underrun_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
    logic [DATA_WIDTH-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [DATA_WIDTH-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
    logic [B_W-1:0]        p_cur, p_nxt;
    logic [IDX_W-1:0]      idx;
    logic                  tick, accept;

    assign p_cur = lrck_q ? b_q - SLOT : b_q;

    always_comb begin
        div_d      = div_q;
        b_d        = b_q;
        bclk_d     = bclk_q;
        lrck_d     = lrck_q;
        adcdat_d   = adcdat_q;
        first_d    = first_q;
        tx_ready_d = tx_ready_q;
        underrun_d = 1'b0;
        rx_valid_d = 1'b0;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        last_l_d   = last_l_q;
        last_r_d   = last_r_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        rx_l_d     = rx_l_q;
        rx_r_d     = rx_r_q;
        p_nxt      = '0;
        idx        = '0;
        tick       = (div_q == DIV_MAX);
        accept     = tx_valid && tx_ready_q;

        // Accept and frame-start load are exclusive: a load needs a full hold.
        if (accept) begin
            hold_l_d   = tx_left;
            hold_r_d   = tx_right;
            tx_ready_d = 1'b0;
        end

        if (!enable) begin
            div_d    = '0;
            b_d      = '0;
            bclk_d   = 1'b0;
            lrck_d   = 1'b0;
            adcdat_d = 1'b0;
            first_d  = 1'b1;
            acc_l_d  = '0;
            acc_r_d  = '0;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                bclk_d = !bclk_q;
                if (!bclk_q) begin
                    if (p_cur >= B_W'(1) && p_cur <= DW_B) begin
                        if (lrck_q) acc_r_d = {acc_r_q[DATA_WIDTH-2:0], AUD_DACDAT};
                        else        acc_l_d = {acc_l_q[DATA_WIDTH-2:0], AUD_DACDAT};
                    end
                    if (lrck_q && p_cur == DW_B) begin
                        rx_l_d     = acc_l_q;
                        rx_r_d     = {acc_r_q[DATA_WIDTH-2:0], AUD_DACDAT};
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    // First fall after idle/reset lands on frame start instead of advancing.
                    first_d = 1'b0;
                    b_d     = (first_q || b_q == B_MAX) ? '0 : b_q + 1'b1;
                    lrck_d  = (b_d >= SLOT);
                    p_nxt   = lrck_d ? b_d - SLOT : b_d;
                    idx     = IDX_W'(DW_B - p_nxt);
                    if (p_nxt >= B_W'(1) && p_nxt <= DW_B)
                        adcdat_d = lrck_d ? last_r_q[idx] : last_l_q[idx];
                    else
                        adcdat_d = 1'b0;
                    if (b_d == '0) begin
                        if (!tx_ready_q) begin
                            last_l_d   = hold_l_q;
                            last_r_d   = hold_r_q;
                            tx_ready_d = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            b_q        <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            adcdat_q   <= 1'b0;
            first_q    <= 1'b1;
            tx_ready_q <= 1'b1;
            underrun_q <= 1'b0;
            rx_valid_q <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            last_l_q   <= '0;
            last_r_q   <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            rx_l_q     <= '0;
            rx_r_q     <= '0;
        end else begin
            div_q      <= div_d;
            b_q        <= b_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            adcdat_q   <= adcdat_d;
            first_q    <= first_d;
            tx_ready_q <= tx_ready_d;
            underrun_q <= underrun_d;
            rx_valid_q <= rx_valid_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            last_l_q   <= last_l_d;
            last_r_q   <= last_r_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            rx_l_q     <= rx_l_d;
            rx_r_q     <= rx_r_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign tx_underrun = underrun_q;
    assign AUD_BCLK    = bclk_q;
    assign AUD_ADCLRCK = lrck_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_ADCDAT  = adcdat_q;
    assign rx_left     = rx_l_q;
    assign rx_right    = rx_r_q;
    assign rx_valid    = rx_valid_q;
endmodule

// File: tb/tb_codec_serial_master.sv
// Directed bench for codec_serial_master: I2S framing, tx handshake/underrun,
// loopback receive, enable idle and asynchronous reset.
module tb_codec_serial_master;
    localparam int DW = 24;
    localparam int SB = 32;
    localparam int BD = 2;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b0;
    logic          enable   = 1'b0;
    logic          tx_valid = 1'b0;
    logic          loop_en  = 1'b0;
    logic [DW-1:0] tx_left  = '0;
    logic [DW-1:0] tx_right = '0;
    logic          tx_ready, tx_underrun, AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK;
    logic          AUD_ADCDAT, AUD_DACDAT, rx_valid;
    logic [DW-1:0] rx_left, rx_right;

    int            ncmp = 0, nfail = 0, un_cnt = 0, rxv_cnt = 0, n_first = 0;
    logic          bclk_prev = 1'b0, fell = 1'b0, idle_ok;
    logic [DW-1:0] rx_l_seen = '0, rx_r_seen = '0;

    codec_serial_master #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .BCLK_DIV(BD)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enable(enable),
        .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_underrun(tx_underrun), .AUD_BCLK(AUD_BCLK),
        .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_ADCDAT(AUD_ADCDAT), .AUD_DACDAT(AUD_DACDAT),
        .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    assign AUD_DACDAT = loop_en ? AUD_ADCDAT : 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; drops tx_valid once the DUT has taken it and tallies pulses.
    task automatic cyc();
        logic a;
        a = tx_valid && tx_ready;
        @(posedge CLOCK_50);
        #1;
        if (a) tx_valid = 1'b0;
        if (tx_underrun) un_cnt++;
        if (rx_valid) begin
            rxv_cnt++;
            rx_l_seen = rx_left;
            rx_r_seen = rx_right;
        end
        fell = bclk_prev && !AUD_BCLK;
        bclk_prev = AUD_BCLK;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!fell && n < 100);
        if (!fell) chk("fall_timeout", 32'(fell), 32'd1);
    endtask

    task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int k;
        tx_left  = l;
        tx_right = r;
        tx_valid = 1'b1;
        k = 0;
        while (tx_valid && k < 600) begin
            cyc();
            k++;
        end
        if (tx_valid) begin
            chk("offer_timeout", 32'(tx_valid), 32'd0);
            tx_valid = 1'b0;
        end
    endtask

    // Walks one whole frame starting at its frame-start fall event.
    task automatic frame(input string tag, input logic [DW-1:0] el, input logic [DW-1:0] er,
                         input int ex_un);
        logic [DW-1:0] l, r;
        logic pad_ok, lr_ok;
        int n, p;
        l = '0; r = '0; pad_ok = 1'b1; lr_ok = 1'b1;
        un_cnt = 0;
        rxv_cnt = 0;
        for (int k = 0; k < 2 * SB; k++) begin
            wait_fall(n);
            if (k == 0) n_first = n;
            p = k % SB;
            if (AUD_ADCLRCK !== (k >= SB) || AUD_DACLRCK !== (k >= SB)) lr_ok = 1'b0;
            if (p >= 1 && p <= DW) begin
                if (k < SB) l = {l[DW-2:0], AUD_ADCDAT};
                else        r = {r[DW-2:0], AUD_ADCDAT};
            end else if (AUD_ADCDAT !== 1'b0) begin
                pad_ok = 1'b0;
            end
        end
        chk({tag, "_adc_left"}, 32'(l), 32'(el));
        chk({tag, "_adc_right"}, 32'(r), 32'(er));
        chk({tag, "_pad_zero"}, 32'(pad_ok), 32'd1);
        chk({tag, "_lrck"}, 32'(lr_ok), 32'd1);
        chk({tag, "_underruns"}, 32'(un_cnt), 32'(ex_un));
        if (loop_en) begin
            chk({tag, "_rx_valid_cnt"}, 32'(rxv_cnt), 32'd1);
            chk({tag, "_rx_left"}, 32'(rx_l_seen), 32'(el));
            chk({tag, "_rx_right"}, 32'(rx_r_seen), 32'(er));
        end
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_bclk", 32'(AUD_BCLK), 32'd0);
        chk("rst_lrck", 32'({AUD_ADCLRCK, AUD_DACLRCK}), 32'd0);
        chk("rst_adcdat", 32'(AUD_ADCDAT), 32'd0);
        chk("rst_underrun", 32'(tx_underrun), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_left", 32'(rx_left), 32'd0);
        chk("rst_rx_right", 32'(rx_right), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        reset_n = 1'b1;
        cyc();

        // Pair offered before the first frame; link then started in loopback
        offer(24'hA50F3C, 24'h800001);
        chk("tx_ready_held", 32'(tx_ready), 32'd0);
        loop_en = 1'b1;
        enable  = 1'b1;
        frame("f1", 24'hA50F3C, 24'h800001, 0);
        chk("first_fall_delay", 32'(n_first), 32'(2 * BD));
        chk("tx_ready_after_load", 32'(tx_ready), 32'd1);

        offer(24'h123456, 24'hFEDCBA);
        frame("f2", 24'h123456, 24'hFEDCBA, 0);

        // Underrun: pair repeated while nothing new is offered
        offer(24'h7FFFFF, 24'h000000);
        frame("f3", 24'h7FFFFF, 24'h000000, 0);
        frame("f4", 24'h7FFFFF, 24'h000000, 1);
        frame("f5", 24'h7FFFFF, 24'h000000, 1);
        chk("tx_ready_underrun", 32'(tx_ready), 32'd1);

        // tx_valid raised on the frame-start cycle while hold is full
        offer(24'h111111, 24'h222222);
        cyc();
        cyc();
        tx_left  = 24'h333333;
        tx_right = 24'h444444;
        tx_valid = 1'b1;
        frame("f6", 24'h111111, 24'h222222, 0);
        chk("collision_hold_full", 32'(tx_ready), 32'd0);
        frame("f7", 24'h333333, 24'h444444, 0);
        frame("f8", 24'h333333, 24'h444444, 1);

        // Drop enable at right slot p=10, hand over a pair while idle
        rxv_cnt = 0;
        for (int k = 0; k < SB + 11; k++) wait_fall(n);
        chk("abort_in_right_slot", 32'(AUD_ADCLRCK), 32'd1);
        enable = 1'b0;
        offer(24'h555555, 24'h666666);
        idle_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (AUD_BCLK !== 1'b0 || AUD_ADCLRCK !== 1'b0 || AUD_DACLRCK !== 1'b0 ||
                AUD_ADCDAT !== 1'b0) idle_ok = 1'b0;
        end
        chk("idle_outputs_low", 32'(idle_ok), 32'd1);
        chk("abort_no_rx_valid", 32'(rxv_cnt), 32'd0);
        chk("idle_tx_ready", 32'(tx_ready), 32'd0);
        chk("idle_rx_retained", 32'(rx_left), 32'h333333);
        enable = 1'b1;
        frame("f9", 24'h555555, 24'h666666, 0);
        chk("reenable_fall_delay", 32'(n_first), 32'(2 * BD));

        // Asynchronous reset mid right slot with hold full
        offer(24'h777777, 24'h020000);
        for (int k = 0; k < SB + 8; k++) wait_fall(n);
        offer(24'h999999, 24'hAAAAAA);
        cyc();
        chk("pre_rst_bclk", 32'(AUD_BCLK), 32'd1);
        chk("pre_rst_lrck", 32'(AUD_ADCLRCK), 32'd1);
        chk("pre_rst_adcdat", 32'(AUD_ADCDAT), 32'd1);
        chk("pre_rst_tx_ready", 32'(tx_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_bclk", 32'(AUD_BCLK), 32'd0);
        chk("arst_lrck", 32'({AUD_ADCLRCK, AUD_DACLRCK}), 32'd0);
        chk("arst_adcdat", 32'(AUD_ADCDAT), 32'd0);
        chk("arst_tx_ready", 32'(tx_ready), 32'd1);
        chk("arst_rx_left", 32'(rx_left), 32'd0);
        chk("arst_rx_right", 32'(rx_right), 32'd0);
        chk("arst_pulses", 32'({tx_underrun, rx_valid}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
